// File: rtl/coh_axi_gate.sv
// coh_axi_gate: coherence gate in front of a memory-side AXI port.
// Before an upstream AR/AW burst is forwarded, every cache block it touches
// is acquired over the coherence master port. The lock is held until the
// burst completes (R last beat or B response). Only address channels pass
// through here; W/R/B are wired externally and R/B are only monitored.
// Optional feature macro: COH_GATE_TIMEOUT_EN (acquisition timeout/re-issue).
module coh_axi_gate #(
    parameter int DW       = 32,
    parameter int BLK      = 64,
    parameter int MAXBYTES = 1024,
    parameter int REQID    = 1,
    parameter int TRSC_RD  = 1,
    parameter int TRSC_WR  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] u_axi_araddr,
    input  logic [7:0]  u_axi_arlen,
    input  logic        u_axi_arvalid,
    output logic        u_axi_arready,
    input  logic [31:0] u_axi_awaddr,
    input  logic [7:0]  u_axi_awlen,
    input  logic        u_axi_awvalid,
    output logic        u_axi_awready,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    input  logic        m_axi_rvalid,
    input  logic        m_axi_rready,
    input  logic        m_axi_rlast,
    input  logic        m_axi_bvalid,
    input  logic        m_axi_bready,
    output logic        m_coh_lock,
    output logic [7:0]  m_coh_rqst,
    output logic [7:0]  m_coh_trsc,
    output logic [63:0] m_coh_addr,
    input  logic [7:0]  m_coh_resp,
    input  logic [7:0]  m_coh_mesi,
    input  logic        s_coh_lock,
    input  logic [7:0]  s_coh_rqst,
    input  logic [7:0]  s_coh_trsc,
    input  logic [63:0] s_coh_addr,
    output logic [7:0]  s_coh_resp,
    output logic [7:0]  s_coh_mesi,
    output logic        err_timeout
);
    localparam int NB      = MAXBYTES / BLK + 1;
    localparam int LOG_BLK = $clog2(BLK);
    localparam int IW      = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_FWD, S_WAIT} state_t;

    state_t          state_q;
    logic [NB-1:0]   req_q, own_q, snt_q, own_d, req_init, cand;
    logic            pend_q, rd_q, pri_aw_q, arvalid_q, awvalid_q, err_q;
    logic [IW-1:0]   pend_idx_q, pick_idx;
    logic            pick_any;
    logic [31:0]     addr_q, base_q;
    logic [7:0]      len_q, coh_rqst_q, coh_trsc_q, sb_q, s_resp_c;
    logic [63:0]     coh_addr_q;
    logic            grant_ar, grant_aw, steal, resp_hit, all_own, locked, tmo_hit;
    logic [31:0]     cap_addr;
    logic [7:0]      cap_len;
    logic [15:0]     nblk_c;

    // Round-robin between AR and AW; pri_aw_q says AW wins the next tie.
    assign grant_ar = u_axi_arvalid & (~u_axi_awvalid | ~pri_aw_q);
    assign grant_aw = u_axi_awvalid & ~grant_ar;
    assign cap_addr = grant_ar ? u_axi_araddr : u_axi_awaddr;
    assign cap_len  = grant_ar ? u_axi_arlen  : u_axi_awlen;

    // Blocks touched by the burst, including the partial leading block.
    assign nblk_c = (16'(cap_addr[LOG_BLK-1:0]) + (16'(cap_len) + 16'd1) * 16'(DW / 8)
                     + 16'(BLK - 1)) >> LOG_BLK;

    // Thermometer mask of slots to acquire; slots past NB do not exist,
    // which clamps the count.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_req
            assign req_init[gi] = (nblk_c > 16'(gi));
        end
    endgenerate

    // Snoops are only refused once every block is owned; yielding during
    // acquisition keeps two gates with partial ownership from deadlocking.
    assign m_coh_lock = (state_q != S_IDLE) & (|req_q);
    assign locked     = m_coh_lock & s_coh_lock & (state_q != S_ACQ);
    assign s_resp_c   = locked ? 8'd0 : sb_q;
    assign s_coh_resp = s_resp_c;
    assign s_coh_mesi = 8'd0;

    assign steal    = (state_q == S_ACQ) && (s_resp_c != 8'd0);
    assign resp_hit = (state_q == S_ACQ) && pend_q && (m_coh_resp == 8'(REQID));
    assign cand     = req_q & ~own_q & ~snt_q;

    // Ownership next-state and lowest-index candidate selection.
    always_comb begin
        own_d = own_q;
        if (steal)
            own_d = '0;
        else if (resp_hit)
            own_d[pend_idx_q] = 1'b1;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_idx = IW'(i);
                pick_any = 1'b1;
            end
        end
    end

    assign all_own = ((req_q & own_d) == req_q);

`ifdef COH_GATE_TIMEOUT_EN
    logic [15:0] cnt_q;
    assign tmo_hit = (state_q == S_ACQ) && (cnt_q == 16'(TIMEOUT - 1)) && !steal && !all_own;
`else
    assign tmo_hit = 1'b0;
`endif

    // Main controller: arbitration, acquisition, forwarding, completion, snoop latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            own_q      <= '0;
            snt_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            rd_q       <= 1'b0;
            pri_aw_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            addr_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            coh_rqst_q <= '0;
            coh_trsc_q <= '0;
            coh_addr_q <= '0;
            sb_q       <= '0;
            err_q      <= 1'b0;
`ifdef COH_GATE_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            coh_rqst_q <= '0;
            coh_trsc_q <= '0;
            coh_addr_q <= '0;
            err_q      <= 1'b0;
            if (s_coh_rqst != 8'd0)
                sb_q <= s_coh_rqst;
            else if (s_resp_c != 8'd0)
                sb_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_ar | grant_aw) begin
                        addr_q   <= cap_addr;
                        len_q    <= cap_len;
                        rd_q     <= grant_ar;
                        base_q   <= {cap_addr[31:LOG_BLK], {LOG_BLK{1'b0}}};
                        req_q    <= req_init;
                        own_q    <= '0;
                        snt_q    <= '0;
                        pend_q   <= 1'b0;
                        pri_aw_q <= grant_ar;
                        state_q  <= S_ACQ;
`ifdef COH_GATE_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                S_ACQ: begin
                    own_q <= own_d;
                    if (resp_hit)
                        pend_q <= 1'b0;
                    if (steal) begin
                        snt_q  <= '0;
                        pend_q <= 1'b0;
                    end else if (all_own) begin
                        state_q   <= S_FWD;
                        arvalid_q <= rd_q;
                        awvalid_q <= ~rd_q;
                    end else if (tmo_hit) begin
                        snt_q  <= '0;
                        pend_q <= 1'b0;
                        err_q  <= 1'b1;
                    end else if (!pend_q && pick_any) begin
                        snt_q[pick_idx] <= 1'b1;
                        pend_q          <= 1'b1;
                        pend_idx_q      <= pick_idx;
                        coh_rqst_q      <= 8'(REQID);
                        coh_trsc_q      <= rd_q ? 8'(TRSC_RD) : 8'(TRSC_WR);
                        coh_addr_q      <= {32'd0, base_q + (32'(pick_idx) << LOG_BLK)};
                    end
`ifdef COH_GATE_TIMEOUT_EN
                    if (resp_hit || tmo_hit)
                        cnt_q <= '0;
                    else
                        cnt_q <= cnt_q + 16'd1;
`endif
                end
                S_FWD: begin
                    if ((arvalid_q & m_axi_arready) | (awvalid_q & m_axi_awready)) begin
                        arvalid_q <= 1'b0;
                        awvalid_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rd_q ? (m_axi_rvalid & m_axi_rready & m_axi_rlast)
                             : (m_axi_bvalid & m_axi_bready)) begin
                        req_q   <= '0;
                        own_q   <= '0;
                        snt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign u_axi_arready = (state_q == S_FWD) & rd_q & m_axi_arready;
    assign u_axi_awready = (state_q == S_FWD) & ~rd_q & m_axi_awready;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_arsize  = 3'($clog2(DW / 8));
    assign m_axi_awsize  = 3'($clog2(DW / 8));
    assign m_axi_arburst = 2'd1;
    assign m_axi_awburst = 2'd1;
    assign m_coh_rqst    = coh_rqst_q;
    assign m_coh_trsc    = coh_trsc_q;
    assign m_coh_addr    = coh_addr_q;
    assign err_timeout   = err_q;

    // Inputs that carry no information this block needs.
    logic unused_sink;
    assign unused_sink = ^{m_coh_mesi, s_coh_trsc, s_coh_addr, 16'(TIMEOUT)};
endmodule

// File: tb/tb_coh_axi_gate.sv
// Directed bench for coh_axi_gate (default build: DW=32, BLK=64, NB=17).
module tb_coh_axi_gate;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] u_axi_araddr, u_axi_awaddr;
    logic [7:0]  u_axi_arlen, u_axi_awlen;
    logic        u_axi_arvalid, u_axi_awvalid, u_axi_arready, u_axi_awready;
    logic [31:0] m_axi_araddr, m_axi_awaddr;
    logic [7:0]  m_axi_arlen, m_axi_awlen;
    logic [2:0]  m_axi_arsize, m_axi_awsize;
    logic [1:0]  m_axi_arburst, m_axi_awburst;
    logic        m_axi_arvalid, m_axi_awvalid, m_axi_arready, m_axi_awready;
    logic        m_axi_rvalid, m_axi_rready, m_axi_rlast, m_axi_bvalid, m_axi_bready;
    logic        m_coh_lock;
    logic [7:0]  m_coh_rqst, m_coh_trsc, m_coh_resp, m_coh_mesi;
    logic [63:0] m_coh_addr;
    logic        s_coh_lock;
    logic [7:0]  s_coh_rqst, s_coh_trsc, s_coh_resp, s_coh_mesi;
    logic [63:0] s_coh_addr;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    coh_axi_gate dut (
        .clk(clk), .rst(rst),
        .u_axi_araddr(u_axi_araddr), .u_axi_arlen(u_axi_arlen),
        .u_axi_arvalid(u_axi_arvalid), .u_axi_arready(u_axi_arready),
        .u_axi_awaddr(u_axi_awaddr), .u_axi_awlen(u_axi_awlen),
        .u_axi_awvalid(u_axi_awvalid), .u_axi_awready(u_axi_awready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_coh_lock(m_coh_lock), .m_coh_rqst(m_coh_rqst), .m_coh_trsc(m_coh_trsc),
        .m_coh_addr(m_coh_addr), .m_coh_resp(m_coh_resp), .m_coh_mesi(m_coh_mesi),
        .s_coh_lock(s_coh_lock), .s_coh_rqst(s_coh_rqst), .s_coh_trsc(s_coh_trsc),
        .s_coh_addr(s_coh_addr), .s_coh_resp(s_coh_resp), .s_coh_mesi(s_coh_mesi),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        bit          rd;
        int          nblk;
        logic [31:0] base;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until a coherence request appears, bounded.
    task automatic wait_rqst(output bit ok);
        int n = 0;
        while (m_coh_rqst == 8'd0 && n < 20) begin
            cyc();
            n++;
        end
        ok = (m_coh_rqst != 8'd0);
        if (!ok) chk("rqst_timeout", 64'(m_coh_rqst), 64'd1);
    endtask

    // Acquire, forward and complete one granted burst.
    task automatic serve(input bit rd, input int nblk, input logic [31:0] base,
                         input logic [31:0] addr, input logic [7:0] len, input bit snoop_wait);
        bit ok;
        for (int k = 0; k < nblk; k++) begin
            wait_rqst(ok);
            if (!ok) return;
            chk("coh_rqst", 64'(m_coh_rqst), 64'd1);
            chk("coh_addr", m_coh_addr, 64'(base + 32'(k) * 32'd64));
            chk("coh_trsc", 64'(m_coh_trsc), rd ? 64'd1 : 64'd2);
            chk("fwd_early", 64'(m_axi_arvalid | m_axi_awvalid), 64'd0);
            chk("lock_acq", 64'(m_coh_lock), 64'd1);
            m_coh_resp = 8'd1;
            cyc();
            m_coh_resp = 8'd0;
            chk("rqst_pulse", 64'(m_coh_rqst), 64'd0);
            if (k == nblk - 1) begin
                chk("fwd_valid_rd", 64'(m_axi_arvalid), 64'(rd));
                chk("fwd_valid_wr", 64'(m_axi_awvalid), 64'(!rd));
            end else begin
                chk("fwd_hold", 64'(m_axi_arvalid | m_axi_awvalid), 64'd0);
            end
        end
        chk("fwd_addr", 64'(rd ? m_axi_araddr : m_axi_awaddr), 64'(addr));
        chk("fwd_len", 64'(rd ? m_axi_arlen : m_axi_awlen), 64'(len));
        m_axi_arready = 1'b1;
        m_axi_awready = 1'b1;
        #1;
        chk("u_arready", 64'(u_axi_arready), 64'(rd));
        chk("u_awready", 64'(u_axi_awready), 64'(!rd));
        cyc();
        m_axi_arready = 1'b0;
        m_axi_awready = 1'b0;
        if (rd) u_axi_arvalid = 1'b0; else u_axi_awvalid = 1'b0;
        chk("valid_drop", 64'(m_axi_arvalid | m_axi_awvalid), 64'd0);
        chk("lock_wait", 64'(m_coh_lock), 64'd1);
        if (snoop_wait) begin
            s_coh_rqst = 8'd3;
            cyc();
            s_coh_rqst = 8'd0;
            chk("snoop_held0", 64'(s_coh_resp), 64'd0);
            cyc();
            chk("snoop_held1", 64'(s_coh_resp), 64'd0);
        end
        if (rd) begin
            m_axi_rvalid = 1'b1; m_axi_rready = 1'b1;
        end else begin
            m_axi_bvalid = 1'b1; m_axi_bready = 1'b0;
        end
        cyc();
        chk("lock_mid", 64'(m_coh_lock), 64'd1);
        if (rd) m_axi_rlast = 1'b1; else m_axi_bready = 1'b1;
        cyc();
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bready = 1'b0;
        chk("lock_done", 64'(m_coh_lock), 64'd0);
        if (snoop_wait) begin
            chk("snoop_release", 64'(s_coh_resp), 64'd3);
            cyc();
            chk("snoop_clear", 64'(s_coh_resp), 64'd0);
        end
        $display("txn %s addr=%08h len=%0d blocks=%0d errors=%0d",
                 rd ? "RD" : "WR", addr, len, nblk, n_errors);
    endtask

    task automatic run_txn(input vec_t v, input bit snoop_wait);
        if (v.rd) begin
            u_axi_araddr = v.addr; u_axi_arlen = v.len; u_axi_arvalid = 1'b1;
        end else begin
            u_axi_awaddr = v.addr; u_axi_awlen = v.len; u_axi_awvalid = 1'b1;
        end
        serve(v.rd, v.nblk, v.base, v.addr, v.len, snoop_wait);
    endtask

    initial begin
        bit ok;
        vec_t v;
        vecs[0] = '{32'h0000_1000, 8'd15,  1'b1, 1,  32'h0000_1000};
        vecs[1] = '{32'h0000_103C, 8'd3,   1'b0, 2,  32'h0000_1000};
        vecs[2] = '{32'h0000_2004, 8'd0,   1'b1, 1,  32'h0000_2000};
        vecs[3] = '{32'h0000_203C, 8'd1,   1'b0, 2,  32'h0000_2000};
        vecs[4] = '{32'h0000_3000, 8'd255, 1'b1, 16, 32'h0000_3000};
        vecs[5] = '{32'h0000_3020, 8'd255, 1'b0, 17, 32'h0000_3000};
        vecs[6] = '{32'h0000_4040, 8'd16,  1'b1, 2,  32'h0000_4040};
        vecs[7] = '{32'hFFFF_FFC0, 8'd0,   1'b0, 1,  32'hFFFF_FFC0};

        rst = 1'b1;
        u_axi_araddr = '0; u_axi_arlen = '0; u_axi_arvalid = 1'b0;
        u_axi_awaddr = '0; u_axi_awlen = '0; u_axi_awvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_awready = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bready = 1'b0;
        m_coh_resp = '0; m_coh_mesi = '0;
        s_coh_lock = 1'b0; s_coh_rqst = '0; s_coh_trsc = '0; s_coh_addr = '0;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset state.
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_arsize", 64'(m_axi_arsize), 64'd2);
        chk("rst_awsize", 64'(m_axi_awsize), 64'd2);
        chk("rst_arburst", 64'(m_axi_arburst), 64'd1);
        chk("rst_awburst", 64'(m_axi_awburst), 64'd1);
        chk("rst_lock", 64'(m_coh_lock), 64'd0);
        chk("rst_rqst", 64'(m_coh_rqst), 64'd0);
        chk("rst_caddr", m_coh_addr, 64'd0);
        chk("rst_sresp", 64'(s_coh_resp), 64'd0);
        chk("rst_smesi", 64'(s_coh_mesi), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_araddr", 64'(m_axi_araddr), 64'd0);

        // Table: block count, alignment and direction.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], 1'b0);
            cyc();
        end

        // Snoop steal during acquisition restarts from block 0.
        u_axi_araddr = 32'h0000_103C; u_axi_arlen = 8'd3; u_axi_arvalid = 1'b1;
        wait_rqst(ok);
        chk("steal_first", m_coh_addr, 64'h1000);
        m_coh_resp = 8'd1;
        cyc();
        m_coh_resp = 8'd0;
        wait_rqst(ok);
        chk("steal_second", m_coh_addr, 64'h1040);
        s_coh_lock = 1'b1;
        s_coh_rqst = 8'd3;
        cyc();
        s_coh_rqst = 8'd0;
        chk("steal_resp", 64'(s_coh_resp), 64'd3);
        cyc();
        chk("steal_sb_clr", 64'(s_coh_resp), 64'd0);
        chk("steal_no_fwd", 64'(m_axi_arvalid), 64'd0);
        serve(1'b1, 2, 32'h0000_1000, 32'h0000_103C, 8'd3, 1'b0);
        cyc();

        // Snoop while the burst is in flight is held off until completion.
        v = '{32'h0000_7000, 8'd0, 1'b1, 1, 32'h0000_7000};
        run_txn(v, 1'b1);
        s_coh_lock = 1'b0;
        cyc();

        // Reset mid-acquisition: lock drops, stale response ignored.
        u_axi_awaddr = 32'h0000_8000; u_axi_awlen = 8'd3; u_axi_awvalid = 1'b1;
        wait_rqst(ok);
        chk("mid_lock", 64'(m_coh_lock), 64'd1);
        rst = 1'b1;
        u_axi_awvalid = 1'b0;
        cyc();
        rst = 1'b0;
        chk("mid_lock_drop", 64'(m_coh_lock), 64'd0);
        chk("mid_rqst", 64'(m_coh_rqst), 64'd0);
        m_coh_resp = 8'd1;
        cyc();
        m_coh_resp = 8'd0;
        cyc();
        chk("mid_no_fwd", 64'(m_axi_awvalid | m_axi_arvalid), 64'd0);
        chk("mid_no_lock", 64'(m_coh_lock), 64'd0);

        // Fair arbitration: AR, AW, AR, AW.
        for (int r = 0; r < 2; r++) begin
            u_axi_araddr = 32'h0000_5000; u_axi_arlen = 8'd0; u_axi_arvalid = 1'b1;
            u_axi_awaddr = 32'h0000_6000; u_axi_awlen = 8'd0; u_axi_awvalid = 1'b1;
            serve(1'b1, 1, 32'h0000_5000, 32'h0000_5000, 8'd0, 1'b0);
            serve(1'b0, 1, 32'h0000_6000, 32'h0000_6000, 8'd0, 1'b0);
            cyc();
        end
        chk("end_err", 64'(err_timeout), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
